// File: rtl/sysid_regbank.sv
// System-identification register bank on an Avalon-MM slave port.
// Read-only identity words, a 64-bit free-running uptime counter with an
// atomic LO/HI snapshot, a control register and a set of scratch registers.
// Reads are registered and return one cycle after the request.
module sysid_regbank #(
    parameter int          ADDR_W      = 4,
    parameter logic [31:0] SYSTEM_ID   = 32'h0000_CAFE,
    parameter logic [31:0] TIMESTAMP   = 32'h637F_84E3,
    parameter logic [31:0] VERSION     = 32'h0001_0000,
    parameter int          NUM_SCRATCH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam logic [ADDR_W-1:0] A_ID    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TS    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_VER   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_UP_LO = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_UP_HI = ADDR_W'(5);
    localparam int                SCR_BASE = 6;

    logic [63:0] up_cnt;
    logic [31:0] hi_snap;
    logic        freeze;
    logic [31:0] scratch [NUM_SCRATCH];

    logic        wr_en;
    logic        clear_hit;
    logic        lo_read;
    logic [31:0] rd_mux;

    // A write that collides with a read is dropped; the read wins.
    assign wr_en     = write & ~read;
    assign clear_hit = wr_en & (address == A_CTRL) & writedata[1];
    assign lo_read   = read & (address == A_UP_LO);

    // Select the word addressed by the current request; unmapped words read 0.
    always_comb begin
        rd_mux = '0;
        case (address)
            A_ID:    rd_mux = SYSTEM_ID;
            A_TS:    rd_mux = TIMESTAMP;
            A_VER:   rd_mux = VERSION;
            A_CTRL:  rd_mux = {31'd0, freeze};
            A_UP_LO: rd_mux = up_cnt[31:0];
            A_UP_HI: rd_mux = hi_snap;
            default: rd_mux = '0;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (address == ADDR_W'(SCR_BASE + i)) begin
                rd_mux = scratch[i];
            end
        end
    end

    // Registered read port; readdata holds between accepted reads.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

    // Uptime counter: CLEAR beats FREEZE beats increment; the LO read edge
    // latches the matching upper half from the same pre-increment value.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            up_cnt  <= '0;
            hi_snap <= '0;
        end else begin
            if (clear_hit) begin
                up_cnt <= '0;
            end else if (!freeze) begin
                up_cnt <= up_cnt + 64'd1;
            end
            if (lo_read) begin
                hi_snap <= up_cnt[63:32];
            end
        end
    end

    // Control register: only FREEZE is stored, CLEAR acts as a pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            freeze <= 1'b0;
        end else if (wr_en && address == A_CTRL) begin
            freeze <= writedata[0];
        end
    end

    // Scratch registers for host software.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (wr_en && address == ADDR_W'(SCR_BASE + i)) begin
                    scratch[i] <= writedata;
                end
            end
        end
    end

endmodule

// File: tb/tb_sysid_regbank.sv
// Self-checking bench for sysid_regbank: directed scenarios with literal
// expectations plus a randomized phase, all checked against a behavioural
// model of the register bank every cycle.
module tb_sysid_regbank;

    localparam int NUM_SCRATCH = 2;

    logic        clock;
    logic        reset_n;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;

    int n_total = 0;
    int n_pass  = 0;

    sysid_regbank #(
        .ADDR_W(4),
        .SYSTEM_ID(32'h0000_CAFE),
        .TIMESTAMP(32'h637F_84E3),
        .VERSION(32'h0001_0000),
        .NUM_SCRATCH(NUM_SCRATCH)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .readdata(readdata),
        .readdatavalid(readdatavalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] bd_val   = '0;
    logic        bd_force = 1'b0;

    logic [63:0] m_up;
    logic        m_freeze;
    logic [31:0] m_snap;
    logic [31:0] m_scr [8];
    logic [31:0] m_rd;
    logic        m_rdv;
    logic        m_known, m_snap_known, m_rd_known;
    logic        m_init = 1'b0;

    always @(posedge clock) begin
        logic [63:0] eff;
        logic        ek, old_freeze, clr;
        int          a;
        a = int'(address);
        if (!reset_n) begin
            m_up = '0; m_freeze = 0; m_snap = '0; m_rd = '0; m_rdv = 0;
            for (int i = 0; i < 8; i++) m_scr[i] = '0;
            m_known = 1; m_snap_known = 1; m_rd_known = 1; m_init = 1;
        end else begin
            eff = bd_force ? bd_val : m_up;
            ek  = bd_force ? 1'b1 : m_known;
            old_freeze = m_freeze;
            m_rdv = read;
            if (read) begin
                m_rd_known = 1;
                if (a == 0) m_rd = 32'h0000_CAFE;
                else if (a == 1) m_rd = 32'h637F_84E3;
                else if (a == 2) m_rd = 32'h0001_0000;
                else if (a == 3) m_rd = {31'd0, m_freeze};
                else if (a == 4) begin
                    m_rd = eff[31:0]; m_rd_known = ek;
                    m_snap = eff[63:32]; m_snap_known = ek;
                end
                else if (a == 5) begin m_rd = m_snap; m_rd_known = m_snap_known; end
                else if (a >= 6 && a < 6 + NUM_SCRATCH) m_rd = m_scr[a-6];
                else m_rd = '0;
            end
            clr = write && !read && a == 3 && writedata[1];
            if (clr) begin
                m_up = '0; m_known = 1;
            end else begin
                m_up = old_freeze ? eff : eff + 64'd1;
                m_known = ek && !bd_force;
            end
            if (write && !read) begin
                if (a == 3) m_freeze = writedata[0];
                if (a >= 6 && a < 6 + NUM_SCRATCH) m_scr[a-6] = writedata;
            end
        end
    end

    // Compare process: every cycle once the model has seen a reset edge.
    always @(negedge clock) begin
        if (m_init) begin
            chk("rdv", {31'd0, readdatavalid}, {31'd0, m_rdv});
            if (m_rd_known) chk("rdata", readdata, m_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic rd(input logic [3:0] a);
        read = 1; write = 0; address = a;
        @(negedge clock);
        read = 0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        write = 1; read = 0; address = a; writedata = d;
        @(negedge clock);
        write = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset_n = 0; read = 0; write = 0; address = '0; writedata = '0;
        repeat (3) @(negedge clock);
        reset_n = 1;

        // 1: identity words back-to-back, unmapped address
        rd(4'd0);  chk("t1_id", readdata, 32'h0000_CAFE); chk("t1_v0", {31'd0, readdatavalid}, 32'd1);
        rd(4'd1);  chk("t1_ts", readdata, 32'h637F_84E3); chk("t1_v1", {31'd0, readdatavalid}, 32'd1);
        rd(4'd2);  chk("t1_ver", readdata, 32'h0001_0000); chk("t1_v2", {31'd0, readdatavalid}, 32'd1);
        rd(4'd15); chk("t1_unmapped", readdata, 32'd0);
        idle(1);   chk("t1_vlow", {31'd0, readdatavalid}, 32'd0);

        // 2: scratch write/read, then reset clears them
        wr(4'd6, 32'hDEAD_BEEF);
        wr(4'd7, 32'h1234_5678);
        rd(4'd6); chk("t2_s0", readdata, 32'hDEAD_BEEF);
        rd(4'd7); chk("t2_s1", readdata, 32'h1234_5678);
        reset_n = 0; @(negedge clock); reset_n = 1;
        rd(4'd6); chk("t2_s0_rst", readdata, 32'd0);
        rd(4'd7); chk("t2_s1_rst", readdata, 32'd0);
        // reset asserted with a read pending: request lost
        reset_n = 0; read = 1; address = 4'd0;
        @(negedge clock);
        reset_n = 1; read = 0;
        chk("t2_rst_rd_lost", {31'd0, readdatavalid}, 32'd0);

        // 3: freeze then clear
        wr(4'd3, 32'd1);
        idle(10);
        rd(4'd4);
        rd(4'd4);
        rd(4'd3); chk("t3_ctrl_frz", readdata, 32'd1);
        wr(4'd3, 32'd2);
        rd(4'd4); chk("t3_lo_after_clr", readdata, 32'd0);
        rd(4'd3); chk("t3_ctrl_clr", readdata, 32'd0);

        // 4: LO-to-HI carry snapshot via backdoor
        bd_val = 64'h0000_0000_FFFF_FFFE;
        bd_force = 1;
        force dut.up_cnt = 64'h0000_0000_FFFF_FFFE;
        read = 1; address = 4'd4;
        @(negedge clock);
        read = 0;
        release dut.up_cnt;
        bd_force = 0;
        chk("t4_lo", readdata, 32'hFFFF_FFFE);
        rd(4'd5); chk("t4_hi_snap", readdata, 32'd0);

        // 5: clear and freeze together, then resume
        wr(4'd3, 32'd3);
        rd(4'd4); chk("t5_lo0", readdata, 32'd0);
        rd(4'd5); chk("t5_hi0", readdata, 32'd0);
        idle(20);
        rd(4'd4); chk("t5_lo_hold", readdata, 32'd0);
        rd(4'd5); chk("t5_hi_hold", readdata, 32'd0);
        wr(4'd3, 32'd0);
        idle(3);
        rd(4'd4); chk("t5_resume", readdata, 32'd3);

        // 6: simultaneous read and write, write dropped
        wr(4'd6, 32'hAAAA_5555);
        read = 1; write = 1; address = 4'd6; writedata = 32'hFFFF_FFFF;
        @(negedge clock);
        read = 0; write = 0;
        chk("t6_old", readdata, 32'hAAAA_5555);
        rd(4'd6); chk("t6_kept", readdata, 32'hAAAA_5555);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset_n   = ($urandom_range(0, 99) != 0);
            read      = ($urandom_range(0, 2) != 0);
            write     = ($urandom_range(0, 3) == 0);
            address   = 4'($urandom_range(0, 15));
            writedata = $urandom;
            if ($urandom_range(0, 3) == 0) writedata[1] = 1'b0;
            @(negedge clock);
        end
        reset_n = 1; read = 0; write = 0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sysid_regbank.md
Name: sysid_regbank

Overview:
- Parametrised Avalon-MM system-identification slave for the SoC.
- Exposes a register bank:
  - read-only identity words: system ID, build timestamp, version;
  - a 64-bit free-running uptime counter with atomic snapshot read;
  - a control register;
  - a configurable number of read/write scratch registers.
- Host software polls the bank to confirm the loaded bitstream and measure elapsed cycles.
- Sits on the same interconnect as the other peripherals.
- Reads are registered, with one cycle of latency.

Parameters:
- ADDR_W, 4: word-address width. Must satisfy 2^ADDR_W >= 6+NUM_SCRATCH.
- SYSTEM_ID, 32'h0000_CAFE: value returned at word 0.
- TIMESTAMP, 32'h637F84E3: build timestamp, returned at word 1.
- VERSION, 32'h0001_0000: major[31:16]/minor[15:0], returned at word 2.
- NUM_SCRATCH, 2: number of 32-bit R/W scratch registers, range 1..8.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- address  in  ADDR_W  word address.
- read  in  1  read strobe, one cycle per request.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high for exactly one cycle, the cycle after an accepted read.

Behaviour:
- One clock. Reset is synchronous and active-low: while reset_n=0 at a rising edge, the following all clear to 0:
  - readdata, readdatavalid;
  - uptime counter UP[63:0] and snapshot HI_SNAP;
  - CTRL;
  - all scratch registers.
- Register map (word address):
  - 0 ID: RO.
  - 1 TS: RO.
  - 2 VER: RO.
  - 3 CTRL: RW.
    - bit0 FREEZE (held).
    - bit1 CLEAR: write-only pulse, always reads 0.
    - bits[31:2] read 0.
  - 4 UP_LO: RO. Returns UP[31:0]; the same edge loads HI_SNAP <= UP[63:32] from the same counter value.
  - 5 UP_HI: RO. Returns HI_SNAP (not the live counter).
  - 6..6+NUM_SCRATCH-1 SCRATCH[i]: RW.
  - All other addresses: reads return 0, writes ignored. No error response.
- Read timing:
  - read=1 at edge N captures the addressed value into readdata.
  - readdatavalid=1 during cycle N+1 only.
  - Back-to-back reads are allowed, one per cycle, with readdatavalid high on consecutive cycles.
  - readdata holds its last value when readdatavalid=0.
- Write timing: write=1 at edge N updates the target register at edge N; it is visible to a read issued in cycle N+1.
- Simultaneous read and write in the same cycle (protocol violation): the read is serviced and the write is dropped.
- Uptime counter:
  - Increments by 1 each edge unless FREEZE=1 or a CLEAR write occurs.
  - Wraps from 2^64-1 to 0 silently.
  - CLEAR write sets UP to 0 at that edge. CLEAR has priority over increment and over FREEZE.
  - A write with bits1:0=11 clears UP and sets FREEZE.
- Snapshot atomicity: reading UP_LO returns UP[31:0] as it was before that edge's increment, and HI_SNAP captures the matching UP[63:32]. The pair {UP_HI, UP_LO} is therefore consistent across a LO-to-HI carry.
- Reading UP_HI without a prior UP_LO read returns the last snapshot (0 after reset).
- Reset asserted mid-read: readdatavalid is 0 on the following cycle and the request is lost.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset release, then reads at addresses 0, 1, 2 in consecutive cycles -> readdatavalid high for 3 consecutive cycles with readdata 0x0000CAFE, 0x637F84E3, 0x00010000. An unmapped address (15) returns 0.
2. Write 0xDEADBEEF to SCRATCH0 (addr 6) and 0x12345678 to SCRATCH1 (addr 7), then read both -> the same values. Assert reset_n=0 for one cycle and re-read -> both 0.
3. Freeze then clear on the counter:
   - Write CTRL=1, wait 10 cycles, read UP_LO twice -> identical values.
   - Write CTRL=2 -> a subsequent read of UP_LO returns a small count.
   - The CTRL read returns 1 (CLEAR reads 0).
4. Force UP=0x0000_0000_FFFF_FFFE via a backdoor force, then read UP_LO at that edge -> LO=0xFFFFFFFE. A following UP_HI read returns 0x00000000 (snapshot), not 0x00000001.
5. Write CTRL=3 (clear and freeze), then read UP_LO and UP_HI -> both 0 and stable over 20 cycles. Write CTRL=0 -> counting resumes.
6. Assert read and write together at addr 6 with writedata 0xFFFFFFFF -> readdata returns the old scratch value and the scratch register is unchanged.
